msg_line_codec: RTL
===================

Name: msg_line_codec

Overview:
- Parametrised serial line-code converter for the message path.
- Generalises the fixed single-bit differential converter with three selectable modes: bypass, NRZI encode and NRZI decode.
- Adds optional bit stuffing/destuffing with configurable run length, valid/ready flow control on both sides, and a stuff-error flag.
- Sits between the message framer and the serial line interface.

Parameters:
- STUFF_LEN, 6, consecutive data 1s after which a 0 is stuffed (encode) or removed (decode); 0 disables stuffing.
- IDLE_LVL, 1, line level after reset/clear (J state).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- mode_i  in  2  0 = BYPASS, 1 = NRZI_ENC, 2 = NRZI_DEC, 3 = reserved (behaves as BYPASS)
- clear_i  in  1  sync clear of line level, run counter and FSM; output register untouched
- s_valid_i  in  1  input bit valid
- s_ready_o  out  1  input bit accepted when s_valid_i && s_ready_o
- s_data_i  in  1  input bit
- m_valid_o  out  1  output bit valid
- m_ready_i  in  1  downstream ready
- m_data_o  out  1  output bit
- stuff_err_o  out  1  one-cycle pulse, decode stuff violation

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-high on rst_i.
- Reset values (rst_i high at a clk_i edge): m_valid_o = 0, m_data_o = 0, stuff_err_o = 0, line level L = IDLE_LVL, run = 0, FSM = ST_DATA.
- Reset mid-stream discards any held output bit.
- Output register:
  - Loaded on the accepting cycle, giving 1-cycle latency.
  - Holds its value while m_valid_o && !m_ready_i.
  - Output slot free = !m_valid_o || m_ready_i.
- s_ready_o = slot free && FSM == ST_DATA. Purely combinational, no dependency on s_valid_i.
- BYPASS: m_data_o = s_data_i. No stuffing, no L/run update.
- NRZI_ENC: per encoded bit d:
  - d = 0 toggles L; d = 1 holds L.
  - The emitted bit is the new L.
  - Data 1 increments run; data 0 clears run.
- NRZI_DEC: per line bit x:
  - d = (x == L) ? 1 : 0, then L <= x.
  - Run counts decoded 1s as in the encoder.
- FSM states ST_DATA and ST_STUFF (only when STUFF_LEN > 0):
  - ENC, ST_DATA: an accepted data 1 that makes run == STUFF_LEN moves the FSM to ST_STUFF.
  - ENC, ST_STUFF: s_ready_o = 0. When the slot is free, emit an encoded 0 (L toggles), clear run, return to ST_DATA.
  - DEC, ST_DATA: an accepted bit decoding to 1 that makes run == STUFF_LEN moves the FSM to ST_STUFF.
  - DEC, ST_STUFF: s_ready_o follows slot free. The next accepted bit updates L but produces no m_valid_o, clears run, and returns to ST_DATA.
  - DEC stuff violation: if that bit decodes to 1, pulse stuff_err_o for one cycle (the cycle after acceptance).
- Run counter width is $clog2(STUFF_LEN+1). It never exceeds STUFF_LEN.
- clear_i: same effect as reset on L, run and FSM. It has priority over a simultaneous input handshake; that input bit is dropped and s_ready_o is forced to 0 in that cycle.
- Changing mode_i is legal only together with clear_i or while s_valid_i = 0 and FSM == ST_DATA. Otherwise behaviour is undefined.
- Full throughput: with m_ready_i held high, one bit accepted per cycle except stuff cycles in ENC.

Test Plan:
- Reset: drive rst_i = 1 for 2 cycles with s_valid_i = 1 -> m_valid_o = 0, stuff_err_o = 0, first post-reset ENC bit 1 emits m_data_o = 1 (IDLE_LVL held).
- ENC, STUFF_LEN = 6, inputs 1,1,1,1,1,1,1 with m_ready_i = 1 -> outputs 1,1,1,1,1,1,0(stuff),0. s_ready_o = 0 exactly one cycle after the 6th accepted bit.
- DEC of line 1,1,1,1,1,1,0,0 from L = 1 -> decoded 1×6 delivered, stuff bit removed, final 1 delivered; 7 m_valid_o beats total, stuff_err_o never set.
- DEC with line 1×7 from L = 1 -> 6 beats of 1, 7th bit dropped, stuff_err_o high for one cycle, run = 0 afterwards.
- Backpressure: ENC stream 0,1,0 with m_ready_i low for 3 cycles after the first beat -> m_data_o stable, s_ready_o = 0 throughout the stall, final output sequence 0,0,1 unchanged.
- Round trip: 200 random bits through ENC then DEC (two instances, random m_ready_i) -> decoded stream equals the input stream, no stuff_err_o; repeat with STUFF_LEN = 0 and BYPASS.

Source files
------------

// File: rtl/msg_line_codec.sv
// Serial line-code converter: bypass, NRZI encode or NRZI decode, with optional
// bit stuffing/destuffing and valid/ready flow control on both sides.
//
// state    | meaning
// ST_DATA  | normal data path, input bits accepted when the output slot is free
// ST_STUFF | run limit reached: ENC inserts a 0, DEC drops the next line bit
module msg_line_codec #(
  parameter int   STUFF_LEN = 6,
  parameter logic IDLE_LVL  = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] mode_i,
  input  logic       clear_i,
  input  logic       s_valid_i,
  output logic       s_ready_o,
  input  logic       s_data_i,
  output logic       m_valid_o,
  input  logic       m_ready_i,
  output logic       m_data_o,
  output logic       stuff_err_o
);

  localparam bit STUFF_EN = (STUFF_LEN > 0);
  localparam int RUN_W    = STUFF_EN ? $clog2(STUFF_LEN + 1) : 1;
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STUFF_LEN);

  localparam logic [1:0] MODE_ENC = 2'd1;
  localparam logic [1:0] MODE_DEC = 2'd2;

  typedef enum logic {
    ST_DATA  = 1'b0,
    ST_STUFF = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic             lvl_q, lvl_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             m_valid_q, m_valid_d;
  logic             m_data_q, m_data_d;
  logic             err_q, err_d;

  logic             slot_free;
  logic             is_enc;
  logic             is_dec;
  logic             s_ready;
  logic             accept;
  logic             dec_bit;
  logic             enc_lvl;
  logic [RUN_W-1:0] run_plus;

  assign slot_free = !m_valid_q || m_ready_i;
  assign is_enc    = (mode_i == MODE_ENC);
  assign is_dec    = (mode_i == MODE_DEC);
  // Decoder keeps accepting in ST_STUFF because the stuffed bit must be consumed.
  assign s_ready   = !clear_i && slot_free && ((state_q == ST_DATA) || is_dec);
  assign accept    = s_valid_i && s_ready;
  assign dec_bit   = (s_data_i == lvl_q);
  assign enc_lvl   = s_data_i ? lvl_q : ~lvl_q;
  assign run_plus  = run_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    lvl_d     = lvl_q;
    run_d     = run_q;
    m_valid_d = m_valid_q && !m_ready_i;
    m_data_d  = m_data_q;
    err_d     = 1'b0;

    if (clear_i) begin
      state_d = ST_DATA;
      lvl_d   = IDLE_LVL;
      run_d   = '0;
    end else if (is_enc) begin
      if (state_q == ST_STUFF) begin
        if (slot_free) begin
          lvl_d     = ~lvl_q;
          m_valid_d = 1'b1;
          m_data_d  = ~lvl_q;
          run_d     = '0;
          state_d   = ST_DATA;
        end
      end else if (accept) begin
        lvl_d     = enc_lvl;
        m_valid_d = 1'b1;
        m_data_d  = enc_lvl;
        if (!s_data_i) begin
          run_d = '0;
        end else if (STUFF_EN) begin
          run_d = run_plus;
          if (run_plus == RUN_MAX) state_d = ST_STUFF;
        end
      end
    end else if (is_dec) begin
      if (accept) begin
        lvl_d = s_data_i;
        if (state_q == ST_STUFF) begin
          run_d   = '0;
          state_d = ST_DATA;
          err_d   = dec_bit;
        end else begin
          m_valid_d = 1'b1;
          m_data_d  = dec_bit;
          if (!dec_bit) begin
            run_d = '0;
          end else if (STUFF_EN) begin
            run_d = run_plus;
            if (run_plus == RUN_MAX) state_d = ST_STUFF;
          end
        end
      end
    end else begin
      // Bypass (and the reserved code): straight copy, line state untouched.
      if (accept) begin
        m_valid_d = 1'b1;
        m_data_d  = s_data_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_DATA;
      lvl_q     <= IDLE_LVL;
      run_q     <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      lvl_q     <= lvl_d;
      run_q     <= run_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      err_q     <= err_d;
    end
  end

  assign s_ready_o   = s_ready;
  assign m_valid_o   = m_valid_q;
  assign m_data_o    = m_data_q;
  assign stuff_err_o = err_q;

endmodule
